// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: registered multicycle sequencer for the MIPS-subset datapath.
// Sequences fetch, decode, execute, memory and writeback. Memory latency is set by
// MEM_LAT, and the controller enters exceptions precisely on illegal opcode,
// overflow and divide-by-zero.
// Optional feature: define CTRL_MULDIV_EN to enable mult/div sequencing through
// MD_WAIT with the md_start/md_done handshake. When it is undefined, mult and div
// decode as illegal instructions.
module multicycle_ctrl #(
  parameter int unsigned MEM_LAT     = 1,     // memory latency in cycles, 1..15
  parameter logic [2:0]  EXC_VEC_SEL = 3'd5   // PCSource code of the exception vector
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       overflowflag,
  input  logic       divby0flag,
  input  logic       md_done,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       WR,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic       EPCWrite,
  output logic [1:0] RegDest,
  output logic [2:0] MemToReg,
  output logic [2:0] ALUSrcB,
  output logic [4:0] ControlType,
  output logic [2:0] PCSource,
  output logic       md_start,
  output logic       md_op,
  output logic [1:0] ExcCause,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC     = 4'd2,
    S_WB       = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_ACC  = 4'd5,
    S_MEM_WB   = 4'd6,
    S_BRANCH   = 4'd7,
    S_JUMP     = 4'd8,
`ifdef CTRL_MULDIV_EN
    S_MD_WAIT  = 4'd9,
`endif
    S_EXC_EPC  = 4'd10,
    S_EXC_JMP  = 4'd11
  } state_t;

  // Instruction class decoded once in DECODE and held for the rest of the instruction.
  typedef enum logic [4:0] {
    C_ADD, C_SUB, C_AND, C_OR, C_SLT,
    C_ADDI, C_ADDIU, C_SLTI, C_LUI,
    C_LW, C_SW, C_BEQ, C_BNE,
    C_J, C_JAL, C_JR, C_RTE,
    C_MULT, C_DIV, C_BREAK, C_ILL
  } iclass_t;

  localparam logic [3:0] LAST_CNT = 4'(MEM_LAT - 1);

  state_t     state_reg;
  iclass_t    cls_reg;
  logic [3:0] cnt_reg;
  logic [1:0] cause_reg;
  iclass_t    dec_cls;
  logic       cnt_last;
  logic       cls_rtype;
  logic       cls_lui;
  logic       cls_ovf_chk;

  function automatic iclass_t classify(input logic [5:0] op, input logic [5:0] fn);
    iclass_t c;
    c = C_ILL;
    case (op)
      6'h00: begin
        case (fn)
          6'h20: c = C_ADD;
          6'h22: c = C_SUB;
          6'h24: c = C_AND;
          6'h25: c = C_OR;
          6'h2A: c = C_SLT;
          6'h08: c = C_JR;
          6'h13: c = C_RTE;
          6'h0D: c = C_BREAK;
`ifdef CTRL_MULDIV_EN
          6'h18: c = C_MULT;
          6'h1A: c = C_DIV;
`endif
          default: c = C_ILL;
        endcase
      end
      6'h08: c = C_ADDI;
      6'h09: c = C_ADDIU;
      6'h0A: c = C_SLTI;
      6'h0F: c = C_LUI;
      6'h23: c = C_LW;
      6'h2B: c = C_SW;
      6'h04: c = C_BEQ;
      6'h05: c = C_BNE;
      6'h02: c = C_J;
      6'h03: c = C_JAL;
      default: c = C_ILL;
    endcase
    return c;
  endfunction

  assign dec_cls     = classify(opcode, funct);
  assign cnt_last    = (cnt_reg == LAST_CNT);
  assign cls_rtype   = (cls_reg == C_ADD) || (cls_reg == C_SUB) || (cls_reg == C_AND) ||
                       (cls_reg == C_OR)  || (cls_reg == C_SLT);
  assign cls_lui     = (cls_reg == C_LUI);
  assign cls_ovf_chk = (cls_reg == C_ADD) || (cls_reg == C_SUB) || (cls_reg == C_ADDI);

`ifdef CTRL_MULDIV_EN
  logic md_op_reg;
  assign md_op = md_op_reg;
`else
  logic unused_md_inputs;
  assign unused_md_inputs = md_done ^ divby0flag;
  assign md_op = 1'b0;
`endif

  // State sequencing, latency counter, latched class, exception cause and md operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_FETCH;
      cnt_reg   <= 4'd0;
      cls_reg   <= C_ILL;
      cause_reg <= 2'd0;
`ifdef CTRL_MULDIV_EN
      md_op_reg <= 1'b0;
`endif
    end else begin
      case (state_reg)
        S_FETCH: begin
          if (cnt_last) begin
            cnt_reg   <= 4'd0;
            state_reg <= S_DECODE;
          end else begin
            cnt_reg <= cnt_reg + 4'd1;
          end
        end
        S_DECODE: begin
          cls_reg <= dec_cls;
          case (dec_cls)
            C_ADD, C_SUB, C_AND, C_OR, C_SLT,
            C_ADDI, C_ADDIU, C_SLTI, C_LUI: state_reg <= S_EXEC;
            C_LW, C_SW:                     state_reg <= S_MEM_ADDR;
            C_BEQ, C_BNE:                   state_reg <= S_BRANCH;
            C_J, C_JAL, C_JR, C_RTE:        state_reg <= S_JUMP;
`ifdef CTRL_MULDIV_EN
            C_MULT, C_DIV: begin
              state_reg <= S_MD_WAIT;
              md_op_reg <= (dec_cls == C_DIV);
            end
`endif
            C_BREAK: state_reg <= S_FETCH;
            default: begin
              state_reg <= S_EXC_EPC;
              cause_reg <= 2'd0;
            end
          endcase
        end
        S_EXEC: begin
          if (overflowflag && cls_ovf_chk) begin
            state_reg <= S_EXC_EPC;
            cause_reg <= 2'd1;
          end else begin
            state_reg <= S_WB;
          end
        end
        S_WB:       state_reg <= S_FETCH;
        S_MEM_ADDR: state_reg <= S_MEM_ACC;
        S_MEM_ACC: begin
          if (cnt_last) begin
            cnt_reg   <= 4'd0;
            state_reg <= (cls_reg == C_LW) ? S_MEM_WB : S_FETCH;
          end else begin
            cnt_reg <= cnt_reg + 4'd1;
          end
        end
        S_MEM_WB: state_reg <= S_FETCH;
        S_BRANCH: state_reg <= S_FETCH;
        S_JUMP:   state_reg <= S_FETCH;
`ifdef CTRL_MULDIV_EN
        // A nonzero counter marks that md_start has already been issued.
        S_MD_WAIT: begin
          if (md_done) begin
            cnt_reg <= 4'd0;
            if (divby0flag) begin
              state_reg <= S_EXC_EPC;
              cause_reg <= 2'd2;
            end else begin
              state_reg <= S_FETCH;
            end
          end else begin
            cnt_reg <= 4'd1;
          end
        end
`endif
        S_EXC_EPC: state_reg <= S_EXC_JMP;
        S_EXC_JMP: state_reg <= S_FETCH;
        default:   state_reg <= S_FETCH;
      endcase
    end
  end

  // Datapath controls decoded from the current state; all are forced to 0 while in reset.
  always_comb begin
    PCWrite     = 1'b0;
    IorD        = 1'b0;
    WR          = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    EPCWrite    = 1'b0;
    RegDest     = 2'd0;
    MemToReg    = 3'd0;
    ALUSrcB     = 3'd0;
    ControlType = 5'd0;
    PCSource    = 3'd0;
    md_start    = 1'b0;
    if (rst_n) begin
      case (state_reg)
        S_FETCH: begin
          ALUSrcB     = 3'd1;
          ControlType = 5'd1;
          if (cnt_last) begin
            IRWrite  = 1'b1;
            PCWrite  = 1'b1;
            PCSource = 3'd1;
          end
        end
        S_DECODE: begin
          ALUSrcB     = 3'd3;
          ControlType = 5'd1;
          if (dec_cls == C_BREAK) begin
            PCWrite  = 1'b1;
            PCSource = 3'd1;
          end
        end
        S_EXEC: begin
          ALUSrcA = 1'b1;
          ALUSrcB = cls_rtype ? 3'd0 : 3'd2;
          case (cls_reg)
            C_ADD, C_ADDI, C_ADDIU: ControlType = 5'd1;
            C_SUB:                  ControlType = 5'd2;
            C_AND:                  ControlType = 5'd3;
            C_OR:                   ControlType = 5'd4;
            C_SLT, C_SLTI:          ControlType = 5'd7;
            default:                ControlType = 5'd0;
          endcase
          if (cls_lui) MemToReg = 3'd5;
        end
        S_WB: begin
          RegWrite = 1'b1;
          RegDest  = cls_rtype ? 2'd1 : 2'd0;
          MemToReg = cls_lui ? 3'd5 : 3'd0;
        end
        S_MEM_ADDR: begin
          ALUSrcA     = 1'b1;
          ALUSrcB     = 3'd2;
          ControlType = 5'd1;
        end
        S_MEM_ACC: begin
          IorD = 1'b1;
          WR   = (cls_reg == C_SW);
        end
        S_MEM_WB: begin
          RegWrite = 1'b1;
          MemToReg = 3'd1;
        end
        S_BRANCH: begin
          ALUSrcA     = 1'b1;
          ControlType = 5'd2;
          PCSource    = 3'd2;
          PCWrite     = ((cls_reg == C_BEQ) && zero) || ((cls_reg == C_BNE) && !zero);
        end
        S_JUMP: begin
          PCWrite = 1'b1;
          case (cls_reg)
            C_JAL: begin
              RegWrite = 1'b1;
              RegDest  = 2'd2;
              MemToReg = 3'd4;
            end
            C_JR: begin
              PCSource = 3'd1;
              ALUSrcA  = 1'b1;
            end
            C_RTE:   PCSource = 3'd4;
            default: PCSource = 3'd0;
          endcase
        end
`ifdef CTRL_MULDIV_EN
        S_MD_WAIT: md_start = (cnt_reg == 4'd0);
`endif
        S_EXC_EPC: begin
          ALUSrcB     = 3'd1;
          ControlType = 5'd2;
          EPCWrite    = 1'b1;
        end
        S_EXC_JMP: begin
          PCSource = EXC_VEC_SEL;
          PCWrite  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign PCWriteCond = 1'b0;
  assign ExcCause    = cause_reg;
  assign state_o     = state_reg;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: cycle-by-cycle check of multicycle_ctrl against an
// instruction-level reference model. Directed cases come first, then random instructions.
module tb_multicycle_ctrl;

  localparam int L = 3;
`ifdef CTRL_MULDIV_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  typedef enum int {
    I_ADD, I_SUB, I_AND, I_OR, I_SLT, I_ADDI, I_ADDIU, I_SLTI, I_LUI,
    I_LW, I_SW, I_BEQ, I_BNE, I_J, I_JAL, I_JR, I_RTE,
    I_MULT, I_DIV, I_BREAK, I_BAD, I_BADR
  } ikind_t;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, pcwc, iord, wr, irw, rw, asa, epcw;
    logic [1:0] rd;
    logic [2:0] m2r, asb;
    logic [4:0] ct;
    logic [2:0] pcs;
    logic       mds, mdo;
    logic [1:0] cause;
  } obs_t;

  logic clk, rst_n;
  logic [5:0] opcode, funct;
  logic zero, overflowflag, divby0flag, md_done;
  logic PCWrite, PCWriteCond, IorD, WR, IRWrite, RegWrite, ALUSrcA, EPCWrite;
  logic [1:0] RegDest, ExcCause;
  logic [2:0] MemToReg, ALUSrcB, PCSource;
  logic [4:0] ControlType;
  logic md_start, md_op;
  logic [3:0] state_o;

  int n_cmp = 0;
  int n_bad = 0;
  logic [1:0] cause_m = 2'd0;
  logic       mdop_m  = 1'b0;
  obs_t obs;

  multicycle_ctrl #(.MEM_LAT(L), .EXC_VEC_SEL(3'd5)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .overflowflag(overflowflag), .divby0flag(divby0flag), .md_done(md_done),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .WR(WR),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .EPCWrite(EPCWrite),
    .RegDest(RegDest), .MemToReg(MemToReg), .ALUSrcB(ALUSrcB),
    .ControlType(ControlType), .PCSource(PCSource), .md_start(md_start),
    .md_op(md_op), .ExcCause(ExcCause), .state_o(state_o)
  );

  assign obs = {state_o, PCWrite, PCWriteCond, IorD, WR, IRWrite, RegWrite, ALUSrcA,
                EPCWrite, RegDest, MemToReg, ALUSrcB, ControlType, PCSource,
                md_start, md_op, ExcCause};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish within time bound");
    $fatal(1, "watchdog");
  end

  function automatic obs_t base(input logic [3:0] st);
    obs_t e;
    e = '0;
    e.st = st;
    e.mdo = mdop_m;
    e.cause = cause_m;
    return e;
  endfunction

  task automatic chk(input obs_t e, input string tag);
    n_cmp++;
    assert (obs === e) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, e);
    end
  endtask

  // Settle, compare this cycle, then advance to just after the next rising edge.
  task automatic step(input obs_t e, input string tag);
    #1;
    chk(e, tag);
    @(posedge clk);
    #1;
  endtask

  task automatic load(input ikind_t k, input logic z, input logic ovf, input logic dz);
    logic [5:0] rf;
    rf = 6'($urandom);
    case (k)
      I_ADD:   begin opcode = 6'h00; funct = 6'h20; end
      I_SUB:   begin opcode = 6'h00; funct = 6'h22; end
      I_AND:   begin opcode = 6'h00; funct = 6'h24; end
      I_OR:    begin opcode = 6'h00; funct = 6'h25; end
      I_SLT:   begin opcode = 6'h00; funct = 6'h2A; end
      I_JR:    begin opcode = 6'h00; funct = 6'h08; end
      I_RTE:   begin opcode = 6'h00; funct = 6'h13; end
      I_MULT:  begin opcode = 6'h00; funct = 6'h18; end
      I_DIV:   begin opcode = 6'h00; funct = 6'h1A; end
      I_BREAK: begin opcode = 6'h00; funct = 6'h0D; end
      I_BADR:  begin opcode = 6'h00; funct = 6'h01; end
      I_ADDI:  begin opcode = 6'h08; funct = rf; end
      I_ADDIU: begin opcode = 6'h09; funct = rf; end
      I_SLTI:  begin opcode = 6'h0A; funct = rf; end
      I_LUI:   begin opcode = 6'h0F; funct = rf; end
      I_LW:    begin opcode = 6'h23; funct = rf; end
      I_SW:    begin opcode = 6'h2B; funct = rf; end
      I_BEQ:   begin opcode = 6'h04; funct = rf; end
      I_BNE:   begin opcode = 6'h05; funct = rf; end
      I_J:     begin opcode = 6'h02; funct = rf; end
      I_JAL:   begin opcode = 6'h03; funct = rf; end
      default: begin opcode = 6'h3F; funct = rf; end
    endcase
    zero = z;
    overflowflag = ovf;
    divby0flag = dz;
  endtask

  task automatic do_fetch(input string nm);
    obs_t e;
    for (int i = 0; i < L; i++) begin
      e = base(4'd0);
      e.asb = 3'd1;
      e.ct = 5'd1;
      if (i == L - 1) begin
        e.irw = 1'b1;
        e.pcw = 1'b1;
        e.pcs = 3'd1;
      end
      step(e, {nm, "/fetch"});
    end
  endtask

  task automatic exc_seq(input string nm);
    obs_t e;
    e = base(4'd10);
    e.asb = 3'd1;
    e.ct = 5'd2;
    e.epcw = 1'b1;
    step(e, {nm, "/exc_epc"});
    e = base(4'd11);
    e.pcs = 3'd5;
    e.pcw = 1'b1;
    step(e, {nm, "/exc_jmp"});
  endtask

  // Reference model of one complete instruction, from fetch until the next fetch.
  task automatic run_instr(input ikind_t k, input logic z, input logic ovf,
                           input int wt, input logic dz, input logic late);
    obs_t e;
    string nm;
    bit is_r, is_alu, is_md;
    nm = k.name();
    load(k, z, ovf, dz);
    md_done = late;
    do_fetch(nm);
    md_done = 1'b0;
    is_r   = k inside {I_ADD, I_SUB, I_AND, I_OR, I_SLT};
    is_alu = is_r || (k inside {I_ADDI, I_ADDIU, I_SLTI, I_LUI});
    is_md  = MD_EN && (k inside {I_MULT, I_DIV});
    e = base(4'd1);
    e.asb = 3'd3;
    e.ct = 5'd1;
    if (k == I_BREAK) begin
      e.pcw = 1'b1;
      e.pcs = 3'd1;
    end
    step(e, {nm, "/decode"});
    if (is_alu) begin
      e = base(4'd2);
      e.asa = 1'b1;
      e.asb = is_r ? 3'd0 : 3'd2;
      case (k)
        I_ADD, I_ADDI, I_ADDIU: e.ct = 5'd1;
        I_SUB:                  e.ct = 5'd2;
        I_AND:                  e.ct = 5'd3;
        I_OR:                   e.ct = 5'd4;
        I_SLT, I_SLTI:          e.ct = 5'd7;
        default:                e.ct = 5'd0;
      endcase
      if (k == I_LUI) e.m2r = 3'd5;
      step(e, {nm, "/exec"});
      if (ovf && (k inside {I_ADD, I_SUB, I_ADDI})) begin
        cause_m = 2'd1;
        exc_seq(nm);
      end else begin
        e = base(4'd3);
        e.rw = 1'b1;
        e.rd = is_r ? 2'd1 : 2'd0;
        e.m2r = (k == I_LUI) ? 3'd5 : 3'd0;
        step(e, {nm, "/wb"});
      end
    end else if (k == I_LW || k == I_SW) begin
      e = base(4'd4);
      e.asa = 1'b1;
      e.asb = 3'd2;
      e.ct = 5'd1;
      step(e, {nm, "/mem_addr"});
      for (int i = 0; i < L; i++) begin
        e = base(4'd5);
        e.iord = 1'b1;
        e.wr = (k == I_SW);
        step(e, {nm, "/mem_acc"});
      end
      if (k == I_LW) begin
        e = base(4'd6);
        e.rw = 1'b1;
        e.m2r = 3'd1;
        step(e, {nm, "/mem_wb"});
      end
    end else if (k == I_BEQ || k == I_BNE) begin
      e = base(4'd7);
      e.asa = 1'b1;
      e.ct = 5'd2;
      e.pcs = 3'd2;
      e.pcw = (k == I_BEQ) ? z : !z;
      step(e, {nm, "/branch"});
    end else if (k inside {I_J, I_JAL, I_JR, I_RTE}) begin
      e = base(4'd8);
      e.pcw = 1'b1;
      if (k == I_JAL) begin
        e.rw = 1'b1;
        e.rd = 2'd2;
        e.m2r = 3'd4;
      end else if (k == I_JR) begin
        e.pcs = 3'd1;
        e.asa = 1'b1;
      end else if (k == I_RTE) begin
        e.pcs = 3'd4;
      end
      step(e, {nm, "/jump"});
    end else if (is_md) begin
      mdop_m = (k == I_DIV);
      for (int w = 0; w <= wt; w++) begin
        e = base(4'd9);
        e.mds = (w == 0);
        md_done = (w == wt);
        step(e, {nm, "/md_wait"});
      end
      md_done = 1'b0;
      if (dz) begin
        cause_m = 2'd2;
        exc_seq(nm);
      end
    end else if (k != I_BREAK) begin
      cause_m = 2'd0;
      exc_seq(nm);
    end
  endtask

  initial begin
    obs_t e;
    rst_n = 1'b0;
    opcode = 6'h00;
    funct = 6'h00;
    zero = 1'b0;
    overflowflag = 1'b0;
    divby0flag = 1'b0;
    md_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk('0, "reset");
    rst_n = 1'b1;

    // Directed cases
    run_instr(I_ADD,  1'b0, 1'b0, 0, 1'b0, 1'b0);
    run_instr(I_LW,   1'b0, 1'b0, 0, 1'b0, 1'b0);
    run_instr(I_ADDI, 1'b0, 1'b1, 0, 1'b0, 1'b0);
    run_instr(I_DIV,  1'b0, 1'b0, 5, 1'b1, 1'b0);
    run_instr(I_BEQ,  1'b0, 1'b0, 0, 1'b0, 1'b0);
    run_instr(I_BNE,  1'b0, 1'b0, 0, 1'b0, 1'b0);
    run_instr(I_MULT, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    run_instr(I_BREAK, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    run_instr(I_RTE,  1'b0, 1'b0, 0, 1'b0, 1'b0);
    run_instr(I_JAL,  1'b0, 1'b0, 0, 1'b0, 1'b0);
    run_instr(I_JR,   1'b0, 1'b0, 0, 1'b0, 1'b0);
    run_instr(I_LUI,  1'b0, 1'b1, 0, 1'b0, 1'b0);
    run_instr(I_SUB,  1'b1, 1'b1, 0, 1'b0, 1'b0);
    run_instr(I_BADR, 1'b0, 1'b0, 0, 1'b0, 1'b0);

    // Reset in the middle of an sw memory access
    load(I_SW, 1'b0, 1'b0, 1'b0);
    do_fetch("sw_rst");
    e = base(4'd1); e.asb = 3'd3; e.ct = 5'd1;
    step(e, "sw_rst/decode");
    e = base(4'd4); e.asa = 1'b1; e.asb = 3'd2; e.ct = 5'd1;
    step(e, "sw_rst/mem_addr");
    e = base(4'd5); e.iord = 1'b1; e.wr = 1'b1;
    step(e, "sw_rst/mem_acc");
    rst_n = 1'b0;
    cause_m = 2'd0;
    mdop_m = 1'b0;
    #1;
    chk('0, "sw_rst/async");
    @(posedge clk);
    #1;
    chk('0, "sw_rst/hold");
    rst_n = 1'b1;
    run_instr(I_ADD, 1'b0, 1'b0, 0, 1'b0, 1'b0);

`ifdef CTRL_MULDIV_EN
    // Reset while waiting on mult/div; a late md_done in FETCH must be ignored
    load(I_DIV, 1'b0, 1'b0, 1'b1);
    do_fetch("div_rst");
    e = base(4'd1); e.asb = 3'd3; e.ct = 5'd1;
    step(e, "div_rst/decode");
    mdop_m = 1'b1;
    e = base(4'd9); e.mds = 1'b1;
    step(e, "div_rst/md_wait");
    rst_n = 1'b0;
    cause_m = 2'd0;
    mdop_m = 1'b0;
    #1;
    chk('0, "div_rst/async");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_instr(I_AND, 1'b0, 1'b0, 0, 1'b1, 1'b1);
`endif

    // Random instruction stream
    for (int n = 0; n < 120; n++) begin
      run_instr(ikind_t'($urandom_range(0, int'(I_BADR))), 1'($urandom),
                ($urandom_range(0, 3) == 0), int'($urandom_range(0, 6)),
                ($urandom_range(0, 2) == 0), ($urandom_range(0, 4) == 0));
    end
    run_instr(I_OR, 1'b0, 1'b0, 0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
